// File: rtl/alu_ctrl_issue.sv
// Decodes a MIPS instruction into a registered ALU control bundle behind a 1-deep valid/ready stage.
// Optional macro ALU_CTRL_ILLEGAL_CNT_EN enables the saturating illegal-instruction counter.
module alu_ctrl_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        amt_sel,
    output logic [4:0]  const_amt,
    output logic [1:0]  logic_func,
    output logic [1:0]  shift_func,
    output logic        add_sub,
    output logic [1:0]  final_func,
    output logic        alu_src_imm,
    output logic [31:0] imm32,
    output logic        ovf_chk,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    localparam logic [1:0] FIN_SHIFT = 2'b00;
    localparam logic [1:0] FIN_SLT   = 2'b01;
    localparam logic [1:0] FIN_ADDER = 2'b10;
    localparam logic [1:0] FIN_LOGIC = 2'b11;
    localparam logic [1:0] SH_SLL    = 2'b01;

    typedef struct packed {
        logic        amt_sel;
        logic [4:0]  const_amt;
        logic [1:0]  logic_func;
        logic [1:0]  shift_func;
        logic        add_sub;
        logic [1:0]  final_func;
        logic        alu_src_imm;
        logic [31:0] imm32;
        logic        ovf_chk;
        logic        illegal;
    } ctrl_t;

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic        w_unused_regs;
    logic        w_accept;
    ctrl_t       w_dec;
    ctrl_t       r_ctrl;
    logic        r_vld;

    assign w_op          = instr[31:26];
    assign w_fn          = instr[5:0];
    assign w_sext        = {{16{instr[15]}}, instr[15:0]};
    assign w_zext        = {16'h0000, instr[15:0]};
    assign w_unused_regs = ^instr[25:16];

    always_comb begin
        w_dec = '0;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h00, 6'h02, 6'h03: begin
                        w_dec.final_func = FIN_SHIFT;
                        w_dec.shift_func = (w_fn[1:0] == 2'b00) ? SH_SLL : w_fn[1:0];
                        w_dec.const_amt  = instr[10:6];
                    end
                    6'h04, 6'h06, 6'h07: begin
                        w_dec.final_func = FIN_SHIFT;
                        w_dec.shift_func = (w_fn[1:0] == 2'b00) ? SH_SLL : w_fn[1:0];
                        w_dec.amt_sel    = 1'b1;
                    end
                    6'h20, 6'h21, 6'h22, 6'h23: begin
                        w_dec.final_func = FIN_ADDER;
                        w_dec.add_sub    = w_fn[1];
                        w_dec.ovf_chk    = ~w_fn[0];
                    end
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        w_dec.final_func = FIN_LOGIC;
                        w_dec.logic_func = w_fn[1:0];
                    end
                    6'h2A: begin
                        w_dec.final_func = FIN_SLT;
                        w_dec.add_sub    = 1'b1;
                    end
                    default: begin
                        w_dec.final_func = FIN_ADDER;
                        w_dec.illegal    = 1'b1;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                w_dec.final_func  = FIN_ADDER;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm32       = w_sext;
                w_dec.ovf_chk     = ~w_op[0];
            end
            6'h0A: begin
                w_dec.final_func  = FIN_SLT;
                w_dec.add_sub     = 1'b1;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm32       = w_sext;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_dec.final_func  = FIN_LOGIC;
                w_dec.logic_func  = w_op[1:0];
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm32       = w_zext;
            end
            // lui is realised as imm << 16 through the shifter
            6'h0F: begin
                w_dec.final_func  = FIN_SHIFT;
                w_dec.shift_func  = SH_SLL;
                w_dec.const_amt   = 5'd16;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm32       = w_zext;
            end
            6'h23, 6'h2B: begin
                w_dec.final_func  = FIN_ADDER;
                w_dec.alu_src_imm = 1'b1;
                w_dec.imm32       = w_sext;
            end
            6'h04, 6'h05: begin
                w_dec.final_func = FIN_ADDER;
                w_dec.add_sub    = 1'b1;
                w_dec.imm32      = w_sext;
            end
            default: begin
                w_dec.final_func = FIN_ADDER;
                w_dec.illegal    = 1'b1;
            end
        endcase
    end

    assign in_ready = !r_vld || out_ready || flush;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_ctrl <= '0;
        end else if (flush) begin
            r_vld  <= 1'b0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_ctrl <= w_dec;
        end else if (out_ready) begin
            r_vld  <= 1'b0;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
    logic [7:0] r_illegal_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal_cnt <= 8'd0;
        end else if (w_accept && w_dec.illegal && (r_illegal_cnt != 8'hFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`else
    assign illegal_cnt = 8'd0;
`endif

    assign out_valid   = r_vld;
    assign amt_sel     = r_ctrl.amt_sel;
    assign const_amt   = r_ctrl.const_amt;
    assign logic_func  = r_ctrl.logic_func;
    assign shift_func  = r_ctrl.shift_func;
    assign add_sub     = r_ctrl.add_sub;
    assign final_func  = r_ctrl.final_func;
    assign alu_src_imm = r_ctrl.alu_src_imm;
    assign imm32       = r_ctrl.imm32;
    assign ovf_chk     = r_ctrl.ovf_chk;
    assign illegal     = r_ctrl.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Randomised scoreboard bench for alu_ctrl_issue with a mnemonic-level reference decoder.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        amt_sel;
    logic [4:0]  const_amt;
    logic [1:0]  logic_func;
    logic [1:0]  shift_func;
    logic        add_sub;
    logic [1:0]  final_func;
    logic        alu_src_imm;
    logic [31:0] imm32;
    logic        ovf_chk;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    always #5 clk = ~clk;

    alu_ctrl_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .amt_sel(amt_sel), .const_amt(const_amt), .logic_func(logic_func),
        .shift_func(shift_func), .add_sub(add_sub), .final_func(final_func),
        .alu_src_imm(alu_src_imm), .imm32(imm32), .ovf_chk(ovf_chk),
        .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    typedef struct packed {
        logic        amt_sel;
        logic [4:0]  const_amt;
        logic [1:0]  logic_func;
        logic [1:0]  shift_func;
        logic        add_sub;
        logic [1:0]  final_func;
        logic        alu_src_imm;
        logic [31:0] imm32;
        logic        ovf_chk;
        logic        illegal;
    } exp_t;

    exp_t     q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       exp_cnt = 0;
    logic     pend_acc = 1'b0;
    logic     pend_rst = 1'b0;
    logic [31:0] pend_instr = 32'h0;
    logic     mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder written per mnemonic from the ALU encoding table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int op, fn;
        logic [31:0] sx, zx;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'h0, w[15:0]};
        e = '0;
        e.final_func = 2;
        if (op == 0) begin
            case (fn)
                'h00: begin e.final_func = 0; e.shift_func = 1; e.const_amt = w[10:6]; end
                'h02: begin e.final_func = 0; e.shift_func = 2; e.const_amt = w[10:6]; end
                'h03: begin e.final_func = 0; e.shift_func = 3; e.const_amt = w[10:6]; end
                'h04: begin e.final_func = 0; e.shift_func = 1; e.amt_sel = 1; end
                'h06: begin e.final_func = 0; e.shift_func = 2; e.amt_sel = 1; end
                'h07: begin e.final_func = 0; e.shift_func = 3; e.amt_sel = 1; end
                'h20: begin e.ovf_chk = 1; end
                'h21: ;
                'h22: begin e.add_sub = 1; e.ovf_chk = 1; end
                'h23: begin e.add_sub = 1; end
                'h24: begin e.final_func = 3; e.logic_func = 0; end
                'h25: begin e.final_func = 3; e.logic_func = 1; end
                'h26: begin e.final_func = 3; e.logic_func = 2; end
                'h27: begin e.final_func = 3; e.logic_func = 3; end
                'h2A: begin e.final_func = 1; e.add_sub = 1; end
                default: e.illegal = 1;
            endcase
        end else begin
            case (op)
                'h08: begin e.alu_src_imm = 1; e.imm32 = sx; e.ovf_chk = 1; end
                'h09: begin e.alu_src_imm = 1; e.imm32 = sx; end
                'h0A: begin e.final_func = 1; e.add_sub = 1; e.alu_src_imm = 1; e.imm32 = sx; end
                'h0C: begin e.final_func = 3; e.logic_func = 0; e.alu_src_imm = 1; e.imm32 = zx; end
                'h0D: begin e.final_func = 3; e.logic_func = 1; e.alu_src_imm = 1; e.imm32 = zx; end
                'h0E: begin e.final_func = 3; e.logic_func = 2; e.alu_src_imm = 1; e.imm32 = zx; end
                'h0F: begin e.final_func = 0; e.shift_func = 1; e.const_amt = 16; e.alu_src_imm = 1; e.imm32 = zx; end
                'h23, 'h2B: begin e.alu_src_imm = 1; e.imm32 = sx; end
                'h04, 'h05: begin e.add_sub = 1; e.imm32 = sx; end
                default: e.illegal = 1;
            endcase
        end
        return e;
    endfunction

    function automatic int sat_limit();
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
        return 255;
`else
        return 0;
`endif
    endfunction

    // One cycle: commit the previous cycle's decision into the model, then drive new inputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                        input logic ordy, input logic rst);
        exp_t e;
        @(posedge clk);
        if (pend_rst) begin
            q.delete();
            exp_cnt = 0;
        end else if (pend_acc) begin
            e = model(pend_instr);
            q.push_back(e);
            if (e.illegal && exp_cnt < sat_limit()) exp_cnt++;
        end
        #1;
        in_valid  = v;
        instr     = ins;
        flush     = fl;
        out_ready = ordy;
        rst_n     = !rst;
        pend_rst  = rst;
        pend_instr = ins;
        pend_acc  = !rst && v && !fl && ((q.size() == 0) || ordy || fl);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("in_ready", 64'(in_ready), 64'((q.size() == 0) || out_ready || flush));
            chk("illegal_cnt", 64'(illegal_cnt), 64'(exp_cnt));
            if (q.size() != 0) begin
                chk("bundle", 64'({amt_sel, const_amt, logic_func, shift_func, add_sub,
                                   final_func, alu_src_imm, imm32, ovf_chk, illegal}),
                    64'(q[0]));
                if (out_ready || flush) void'(q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [5:0] rfn[16];
        logic [5:0] iop[13];
        logic [31:0] w;
        rfn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h01};
        iop = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                6'h2B, 6'h04, 6'h05, 6'h3F, 6'h02};
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: w[31:26] = 6'h00;
            4, 5, 6, 7: w[31:26] = iop[$urandom_range(0, 12)];
            default: ;
        endcase
        if (w[31:26] == 6'h00 && $urandom_range(0, 7) != 0) w[5:0] = rfn[$urandom_range(0, 15)];
        return w;
    endfunction

    initial begin
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        @(negedge clk);
        chk("reset_state", 64'({out_valid, amt_sel, const_amt, logic_func, shift_func, add_sub,
                                final_func, alu_src_imm, imm32, ovf_chk, illegal, illegal_cnt}), 64'h0);
        mon_en = 1'b1;

        step(1, 32'h00851020, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        @(negedge clk);
        chk("add_fields", 64'({out_valid, final_func, add_sub, ovf_chk, alu_src_imm}),
            64'({1'b1, 2'b10, 1'b0, 1'b1, 1'b0}));

        step(1, 32'h3C01ABCD, 0, 1, 0);
        step(1, 32'h2002FFFF, 0, 1, 0);
        @(negedge clk);
        chk("lui_fields", 64'({final_func, amt_sel, const_amt, imm32}),
            64'({2'b00, 1'b0, 5'd16, 32'h0000ABCD}));
        step(0, 32'h0, 0, 1, 0);
        @(negedge clk);
        chk("addi_imm", 64'(imm32), 64'hFFFFFFFF);

        step(1, 32'h00A62022, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h34A5F00F, 0, 0, 0);
        step(1, 32'h34A5F00F, 0, 1, 0);
        step(1, 32'h00042082, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);

        step(1, 32'h8C220004, 0, 0, 0);
        step(1, 32'hFC000000, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);

        step(0, 32'h0, 0, 1, 1);
        step(0, 32'h0, 0, 1, 0);
        for (int i = 0; i < 260; i++) step(1, 32'hFC000000, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        @(negedge clk);
        chk("cnt_saturate", 64'(illegal_cnt), 64'(sat_limit()));
        step(1, 32'hFC000000, 0, 1, 0);
        step(1, 32'hFC000000, 0, 1, 1);
        step(1, 32'hFC000000, 0, 0, 0);
        @(negedge clk);
        chk("cnt_after_rst", 64'({out_valid, illegal_cnt}), 64'h0);
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 1, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
